dmem_mmio: RTL and testbench

Data-side memory responder for the RV32I cpu. It answers the cpu's data port (mem_write, data_adr, write_data, read_data) and replaces the bare dmem. It provides word RAM plus a small memory-mapped I/O window:
- halt/verdict register
- free-running cycle counter
- byte transmit FIFO with a valid/ready output stream

Benches and the FPGA top use the done/pass flags and the tx stream instead of snooping the bus.

---
 rtl/dmem_mmio_pkg.sv | 38 +++
 rtl/dmem_mmio_tx_fifo.sv | 62 ++++++
 rtl/dmem_mmio.sv | 126 ++++++++++++
 tb/tb_dmem_mmio.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-side memory responder: MMIO addresses,
// TXSTAT field positions and the address decoder.
package dmem_mmio_pkg;

    localparam logic [31:0] HALT_ADDR   = 32'hFFFF_FFF0;
    localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_FFF4;
    localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_FFF8;
    localparam logic [31:0] TXSTAT_ADDR = 32'hFFFF_FFFC;

    localparam int TXSTAT_OVERFLOW_BIT = 15;
    localparam int TXSTAT_FULL_BIT     = 14;
    localparam int TXSTAT_EMPTY_BIT    = 13;

    localparam logic [31:0] PASS_VALUE = 32'd1;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_HALT,
        REG_CYCLE,
        REG_TXDATA,
        REG_TXSTAT,
        REG_NONE
    } region_e;

    // Decode on word address only; the byte offset never selects a register.
    function automatic region_e decode_region(input logic [29:0] word,
                                              input logic [29:0] ram_words);
        region_e r;
        if (word < ram_words)                   r = REG_RAM;
        else if (word == HALT_ADDR[31:2])       r = REG_HALT;
        else if (word == CYCLE_ADDR[31:2])      r = REG_CYCLE;
        else if (word == TXDATA_ADDR[31:2])     r = REG_TXDATA;
        else if (word == TXSTAT_ADDR[31:2])     r = REG_TXSTAT;
        else                                    r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Synchronous FIFO with separate occupancy counter; pushes to a full FIFO
// are dropped unless a pop frees the slot in the same cycle.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]       data_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + (PTR_W+1)'(1);
        else if (do_pop && !do_push)
            count_d = count_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (do_push)
            mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);

endmodule

// File: rtl/dmem_mmio.sv
// Data-port responder for the RV32I core: word RAM plus an MMIO window with
// halt/verdict flags, a free-running cycle counter and a byte tx stream.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int    RAM_WORDS  = 4096,
    parameter int    FIFO_DEPTH = 8,
    parameter string MEM_FILE   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done,
    output logic        pass
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_q [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    region_e           region;

    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [31:0] cycle_q, cycle_d;
    logic        overflow_q, overflow_d;

    logic             wr_halt, wr_cycle, wr_txdata, wr_txstat;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_data;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_addr_bits;

    assign ram_idx          = a[RAM_AW+1:2];
    assign unused_addr_bits = ^a[1:0];

    always_comb begin
        region    = decode_region(a[31:2], 30'(RAM_WORDS));
        wr_halt   = we && (region == REG_HALT);
        wr_cycle  = we && (region == REG_CYCLE);
        wr_txdata = we && (region == REG_TXDATA);
        wr_txstat = we && (region == REG_TXSTAT);
        fifo_pop  = !fifo_empty && tx_ready;

        done_d = done_q;
        pass_d = pass_q;
        if (wr_halt && !done_q) begin
            done_d = 1'b1;
            pass_d = (wd == PASS_VALUE);
        end

        cycle_d = wr_cycle ? wd : cycle_q + 32'd1;

        // A slot freed by a same-cycle pop absorbs the push, so no overflow.
        overflow_d = overflow_q;
        if (wr_txdata && fifo_full && !fifo_pop)
            overflow_d = 1'b1;
        else if (wr_txstat && wd[0])
            overflow_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q     <= done_d;
            pass_q     <= pass_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
        end
    end

    // RAM is deliberately outside reset so a write during reset still lands.
    always_ff @(posedge clock) begin
        if (we && (region == REG_RAM))
            ram_q[ram_idx] <= wd;
    end

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (wr_txdata),
        .pop      (fifo_pop),
        .data_in  (wd[7:0]),
        .data_out (fifo_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        rd = '0;
        case (region)
            REG_RAM:    rd = ram_q[ram_idx];
            REG_HALT:   rd = {30'b0, pass_q, done_q};
            REG_CYCLE:  rd = cycle_q;
            REG_TXDATA: rd = fifo_empty ? 32'd0 : {24'b0, fifo_data};
            REG_TXSTAT: begin
                rd[TXSTAT_OVERFLOW_BIT] = overflow_q;
                rd[TXSTAT_FULL_BIT]     = fifo_full;
                rd[TXSTAT_EMPTY_BIT]    = fifo_empty;
                rd[7:0]                 = 8'(fifo_count);
            end
            default:    rd = '0;
        endcase
    end

    assign tx_data  = fifo_data;
    assign tx_valid = !fifo_empty;
    assign done     = done_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: a vector table for RAM/HALT/decode
// plus hand-written sequences for the cycle counter, tx FIFO and mid-run reset.
module tb_dmem_mmio;

    localparam logic [31:0] A_HALT   = 32'hFFFF_FFF0;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_FFF4;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_FFF8;
    localparam logic [31:0] A_TXSTAT = 32'hFFFF_FFFC;

    logic        clock;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        done;
    logic        pass;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_done;
        logic        exp_pass;
    } vec_t;

    vec_t vecs [20];

    dmem_mmio #(
        .RAM_WORDS  (4096),
        .FIFO_DEPTH (8),
        .MEM_FILE   ("")
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .we       (we),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (done),
        .pass     (pass)
    );

    // Period 20; inputs move just after the falling edge, far from posedge.
    initial clock = 1'b0;
    always #10 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkRd(input string name, input logic [31:0] addr,
                           input logic [31:0] expected);
        a = addr;
        #1;
        checkOutput(name, rd, expected);
    endtask

    // One table row = one clock: outputs checked against state before the edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        we = v.we;
        a  = v.a;
        wd = v.wd;
        #1;
        if (v.chk_rd)
            checkOutput($sformatf("vec%0d rd", idx), rd, v.exp_rd);
        checkOutput($sformatf("vec%0d done", idx), {31'b0, done}, {31'b0, v.exp_done});
        checkOutput($sformatf("vec%0d pass", idx), {31'b0, pass}, {31'b0, v.exp_pass});
        checkOutput($sformatf("vec%0d tx_valid", idx), {31'b0, tx_valid}, 32'd0);
        tick();
    endtask

    initial begin
        logic [7:0] drain_exp [8];

        //           we    addr          wd            chk   exp_rd        done  pass
        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0102, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_8000, 32'h0,         1'b1, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0104, 32'h1234_5678, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0104, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'hFFFF_FFEC, 32'h1,         1'b1, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{1'b0, A_HALT,        32'h0,         1'b1, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{1'b1, A_HALT,        32'h1,         1'b1, 32'h0,        1'b0, 1'b0};
        vecs[9]  = '{1'b0, A_HALT,        32'h0,         1'b1, 32'h3,        1'b1, 1'b1};
        vecs[10] = '{1'b1, A_HALT,        32'h2,         1'b1, 32'h3,        1'b1, 1'b1};
        vecs[11] = '{1'b0, A_HALT,        32'h0,         1'b1, 32'h3,        1'b1, 1'b1};
        vecs[12] = '{1'b0, 32'hFFFF_FFF3, 32'h0,         1'b1, 32'h3,        1'b1, 1'b1};
        vecs[13] = '{1'b0, A_TXSTAT,      32'h0,         1'b1, 32'h0000_2000, 1'b1, 1'b1};
        vecs[14] = '{1'b0, A_TXDATA,      32'h0,         1'b1, 32'h0,        1'b1, 1'b1};
        vecs[15] = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[16] = '{1'b0, 32'h0000_3FFC, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 32'h0000_4000, 32'h0,         1'b1, 32'h0,        1'b1, 1'b1};
        vecs[18] = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 32'h0000_8000, 32'h55,        1'b1, 32'h0,        1'b1, 1'b1};

        drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};

        reset    = 1'b1;
        we       = 1'b0;
        a        = '0;
        wd       = '0;
        tx_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        #1;
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset pass", {31'b0, pass}, 32'd0);
        checkOutput("reset tx_valid", {31'b0, tx_valid}, 32'd0);
        checkRd("reset cycle", A_CYCLE, 32'd0);
        checkRd("reset txstat", A_TXSTAT, 32'h0000_2000);

        // Table: RAM, decode boundaries, sticky halt verdict
        for (int i = 0; i < 20; i++)
            applyStimulus(vecs[i], i);

        // Reset clears flags; MMIO writes ignored in reset, RAM writes land
        reset = 1'b1;
        we    = 1'b1;
        a     = A_HALT;
        wd    = 32'd1;
        tick();
        a  = 32'h0000_0200;
        wd = 32'hA5A5_A5A5;
        tick();
        reset = 1'b0;
        we    = 1'b0;
        #1;
        checkOutput("rst2 done", {31'b0, done}, 32'd0);
        checkOutput("rst2 pass", {31'b0, pass}, 32'd0);
        checkRd("rst2 halt rd", A_HALT, 32'd0);
        checkRd("rst2 ram write", 32'h0000_0200, 32'hA5A5_A5A5);
        checkRd("rst2 ram kept", 32'h0000_0100, 32'hDEAD_BEEF);

        // Cycle counter: idle count, load, wrap
        repeat (10) tick();
        checkRd("cycle idle10", A_CYCLE, 32'd10);
        we = 1'b1;
        wd = 32'hFFFF_FFFE;
        tick();
        we = 1'b0;
        checkRd("cycle load", A_CYCLE, 32'hFFFF_FFFE);
        tick();
        checkRd("cycle ffffffff", A_CYCLE, 32'hFFFF_FFFF);
        tick();
        checkRd("cycle wrap", A_CYCLE, 32'h0000_0000);

        // Fill FIFO past full with consumer stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            we = 1'b1;
            a  = A_TXDATA;
            wd = {24'b0, 8'(8'h41 + i)};
            if (i == 0) begin
                #1;
                checkOutput("push empty tx_valid pre", {31'b0, tx_valid}, 32'd0);
            end
            tick();
            if (i == 0) begin
                checkOutput("push empty tx_valid post", {31'b0, tx_valid}, 32'd1);
                checkOutput("push empty tx_data", {24'b0, tx_data}, 32'h41);
            end
        end
        we = 1'b0;
        checkRd("overflow txstat", A_TXSTAT, 32'h0000_C008);
        checkRd("overflow txdata rd", A_TXDATA, 32'h41);
        checkOutput("overflow tx_data", {24'b0, tx_data}, 32'h41);

        we = 1'b1;
        a  = A_TXSTAT;
        wd = 32'd1;
        tick();
        we = 1'b0;
        checkRd("ovf clear txstat", A_TXSTAT, 32'h0000_4008);

        // Head must hold while stalled
        tick();
        tick();
        checkOutput("stall tx_data", {24'b0, tx_data}, 32'h41);
        checkOutput("stall tx_valid", {31'b0, tx_valid}, 32'd1);

        // Push and pop together while full
        we       = 1'b1;
        a        = A_TXDATA;
        wd       = 32'h5A;
        tx_ready = 1'b1;
        tick();
        we       = 1'b0;
        tx_ready = 1'b0;
        checkRd("full pushpop txstat", A_TXSTAT, 32'h0000_4008);
        checkOutput("full pushpop tx_data", {24'b0, tx_data}, 32'h42);

        // Drain in order
        tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput($sformatf("drain%0d tx_valid", k), {31'b0, tx_valid}, 32'd1);
            checkOutput($sformatf("drain%0d tx_data", k), {24'b0, tx_data}, {24'b0, drain_exp[k]});
            tick();
        end
        tx_ready = 1'b0;
        #1;
        checkOutput("drained tx_valid", {31'b0, tx_valid}, 32'd0);
        checkRd("drained txstat", A_TXSTAT, 32'h0000_2000);

        // Reset with bytes queued and consumer ready
        for (int i = 0; i < 3; i++) begin
            we = 1'b1;
            a  = A_TXDATA;
            wd = {24'b0, 8'(8'h11 * (i + 1))};
            tick();
        end
        we = 1'b0;
        checkRd("three queued txstat", A_TXSTAT, 32'h0000_0003);
        tx_ready = 1'b1;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        tx_ready = 1'b0;
        #1;
        checkOutput("rst3 tx_valid", {31'b0, tx_valid}, 32'd0);
        checkRd("rst3 txstat", A_TXSTAT, 32'h0000_2000);
        checkRd("rst3 cycle", A_CYCLE, 32'd0);

        // Failing verdict
        we = 1'b1;
        a  = A_HALT;
        wd = 32'd7;
        tick();
        we = 1'b0;
        checkRd("fail verdict rd", A_HALT, 32'd1);
        checkOutput("fail verdict done", {31'b0, done}, 32'd1);
        checkOutput("fail verdict pass", {31'b0, pass}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
